// File: rtl/exec_ctrl_pkg.sv
// exec_ctrl_pkg: shared state encoding and default widths for the run/halt/step sequencer
package exec_ctrl_pkg;
  typedef enum logic [1:0] {HALT = 2'd0, RUN = 2'd1, STEP = 2'd2} state_t;
  localparam int DEF_AW = 8;
  localparam int DEF_CW = 16;
endpackage

// File: rtl/exec_ctrl.sv
// exec_ctrl: gates decoder write enables by run/halt/step state with breakpoint and watchdog
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int CW = DEF_CW,
  parameter int LIMIT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          halt,
  input  logic          step,
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr,
  input  logic [AW-1:0] pa,
  input  logic          pwe_in,
  input  logic          rwe_in,
  input  logic          mwe_in,
  output logic          pwe,
  output logic          rwe,
  output logic          mwe,
  output logic          commit,
  output logic          running,
  output logic          bp_hit,
  output logic          wd_hit,
  output logic [CW-1:0] icount
);
  localparam int RW = LIMIT > 0 ? $clog2(LIMIT + 1) : 1;
  localparam logic [RW-1:0] LIM = RW'(LIMIT);
  state_t st;
  logic [RW-1:0] rl;
  logic skip_bp, bp_match, wd_exp;
  assign bp_match = bp_en && pa == bp_addr && !skip_bp;
  assign wd_exp = LIMIT != 0 && rl == LIM;
  assign commit = !rst && (st == STEP || (st == RUN && !halt && !bp_match && !wd_exp));
  assign pwe = pwe_in && commit;
  assign rwe = rwe_in && commit;
  assign mwe = mwe_in && commit;
  // skip_bp lets a resume execute the instruction it stopped on exactly once
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= HALT;
      running <= 1'b0;
      bp_hit <= 1'b0;
      wd_hit <= 1'b0;
      icount <= '0;
      rl <= '0;
      skip_bp <= 1'b0;
    end else begin
      if (commit) begin
        icount <= icount + 1'b1;
        skip_bp <= 1'b0;
      end
      case (st)
        HALT: if (!halt && (step || run)) begin
          st <= step ? STEP : RUN;
          running <= !step;
          bp_hit <= 1'b0;
          wd_hit <= 1'b0;
          skip_bp <= 1'b1;
          rl <= '0;
        end
        RUN: if (halt || bp_match || wd_exp) begin
          st <= HALT;
          running <= 1'b0;
          bp_hit <= !halt && bp_match;
          wd_hit <= !halt && wd_exp;
        end else rl <= rl + RW'(LIMIT != 0 && rl != LIM);
        default: begin
          st <= HALT;
          running <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: directed and random stimulus against a behavioural model, LIMIT=0 and LIMIT=3 builds
module tb_exec_ctrl;
  import exec_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst, run, halt, step, bp_en, pwe_in, rwe_in, mwe_in;
  logic [DEF_AW-1:0] bp_addr, pa0, pa3;
  logic pwe0, rwe0, mwe0, commit0, running0, bp0, wd0;
  logic pwe3, rwe3, mwe3, commit3, running3, bp3, wd3;
  logic [DEF_CW-1:0] ic0, ic3;
  int total = 0, bad = 0;
  logic [DEF_AW-1:0] mpa [2];
  int cnt [2], rl [2];
  bit going [2], single [2], skip [2], bph [2], wdh [2];
  int lim [2] = '{0, 3};

  always #5 clk = ~clk;
  assign pa0 = mpa[0];
  assign pa3 = mpa[1];

  exec_ctrl #(.AW(DEF_AW), .CW(DEF_CW), .LIMIT(0)) d0 (
    .clk(clk), .rst(rst), .run(run), .halt(halt), .step(step), .bp_en(bp_en),
    .bp_addr(bp_addr), .pa(pa0), .pwe_in(pwe_in), .rwe_in(rwe_in), .mwe_in(mwe_in),
    .pwe(pwe0), .rwe(rwe0), .mwe(mwe0), .commit(commit0), .running(running0),
    .bp_hit(bp0), .wd_hit(wd0), .icount(ic0));

  exec_ctrl #(.AW(DEF_AW), .CW(DEF_CW), .LIMIT(3)) d3 (
    .clk(clk), .rst(rst), .run(run), .halt(halt), .step(step), .bp_en(bp_en),
    .bp_addr(bp_addr), .pa(pa3), .pwe_in(pwe_in), .rwe_in(rwe_in), .mwe_in(mwe_in),
    .pwe(pwe3), .rwe(rwe3), .mwe(mwe3), .commit(commit3), .running(running3),
    .bp_hit(bp3), .wd_hit(wd3), .icount(ic3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit bpm(int k);
    return bp_en && mpa[k] == bp_addr && !skip[k];
  endfunction

  function automatic bit wdx(int k);
    return lim[k] != 0 && rl[k] >= lim[k];
  endfunction

  function automatic bit mc(int k);
    return !rst && (single[k] || (going[k] && !halt && !bpm(k) && !wdx(k)));
  endfunction

  task automatic check_all;
    chk("commit0", commit0, mc(0));
    chk("we0", {pwe0, rwe0, mwe0}, {pwe_in, rwe_in, mwe_in} & {3{mc(0)}});
    chk("flags0", {running0, bp0, wd0}, {going[0], bph[0], wdh[0]});
    chk("icount0", ic0, cnt[0]);
    chk("commit3", commit3, mc(1));
    chk("we3", {pwe3, rwe3, mwe3}, {pwe_in, rwe_in, mwe_in} & {3{mc(1)}});
    chk("flags3", {running3, bp3, wd3}, {going[1], bph[1], wdh[1]});
    chk("icount3", ic3, cnt[1]);
  endtask

  task automatic update(input int k);
    bit c, b, w;
    logic [DEF_AW-1:0] tgt;
    c = mc(k);
    b = bpm(k);
    w = wdx(k);
    if (rst) begin
      going[k] = 0; single[k] = 0; skip[k] = 0; bph[k] = 0; wdh[k] = 0;
      cnt[k] = 0; rl[k] = 0; mpa[k] = '0;
      return;
    end
    if (c) begin
      cnt[k] = (cnt[k] + 1) % 65536;
      skip[k] = 0;
      tgt = DEF_AW'($urandom_range(0, 7));
      mpa[k] = pwe_in ? tgt : mpa[k] + 1'b1;
    end
    if (single[k]) single[k] = 0;
    else if (going[k]) begin
      if (halt) going[k] = 0;
      else if (b || w) begin
        going[k] = 0; bph[k] = b; wdh[k] = w;
      end else if (rl[k] < lim[k]) rl[k]++;
    end else if (!halt && (step || run)) begin
      bph[k] = 0; wdh[k] = 0; skip[k] = 1; rl[k] = 0;
      single[k] = step; going[k] = !step;
    end
  endtask

  task automatic tick;
    #1;
    check_all();
    @(posedge clk);
    #1;
    update(0);
    update(1);
    @(negedge clk);
  endtask

  task automatic drive(input bit r, input bit h, input bit s);
    run = r; halt = h; step = s;
  endtask

  initial begin
    rst = 1; drive(0, 0, 0); bp_en = 0; bp_addr = '0;
    pwe_in = 0; rwe_in = 0; mwe_in = 0;
    mpa[0] = '0; mpa[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    update(0);
    update(1);
    @(negedge clk);
    rst = 0;
    pwe_in = 1; rwe_in = 1; mwe_in = 1;
    repeat (10) tick();
    chk("idle_icount", ic0, 0);
    pwe_in = 0;
    drive(1, 0, 0);
    repeat (6) tick();
    drive(1, 1, 0);
    tick();
    drive(0, 0, 0);
    tick();
    chk("run5_icount", ic0, 5);
    chk("run5_halted", running0, 0);
    rst = 1;
    tick();
    rst = 0;
    bp_en = 1; bp_addr = 8'h04;
    drive(1, 0, 0);
    repeat (6) tick();
    chk("bp_icount", ic0, 4);
    chk("bp_hit", bp0, 1);
    drive(0, 0, 0);
    tick();
    drive(1, 0, 0);
    repeat (2) tick();
    chk("bp_resume_icount", ic0, 5);
    chk("bp_resume_clear", bp0, 0);
    drive(0, 1, 0);
    tick();
    bp_addr = 8'h05;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1);
      tick();
      drive(0, 0, 0);
      tick();
      chk("step_halted", running0, 0);
    end
    chk("step_icount", ic0, 8);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 149) == 0;
      run = $urandom_range(0, 9) < 7;
      halt = $urandom_range(0, 9) == 0;
      step = $urandom_range(0, 9) < 2;
      bp_en = $urandom_range(0, 1) == 1;
      bp_addr = DEF_AW'($urandom_range(0, 9));
      pwe_in = $urandom_range(0, 9) < 2;
      rwe_in = $urandom_range(0, 1) == 1;
      mwe_in = $urandom_range(0, 1) == 1;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exec_ctrl.md
Name: exec_ctrl

Overview:
Run/halt/step sequencer for the 16-bit single-cycle core. Sits between the decoder and the state elements (pc, regfile, omem). Gates the decoder's write enables so that an instruction commits only when execution is permitted. Adds a program-address breakpoint, single-step, a committed-instruction counter and a run-limit watchdog for bring-up and debug.

Parameters:
AW, 8, program address width (pc / imem address)
CW, 16, committed-instruction counter width
LIMIT, 0, watchdog: halt after LIMIT commits in one run; 0 disables

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
run  in  1  request continuous execution (level, sampled each cycle)
halt  in  1  request stop (level)
step  in  1  request exactly one commit (pulse; a level is treated as repeated requests)
bp_en  in  1  breakpoint enable
bp_addr  in  AW  breakpoint program address
pa  in  AW  current pc value
pwe_in  in  1  pc write enable from decoder
rwe_in  in  1  regfile write enable from decoder
mwe_in  in  1  data-memory write enable from decoder
pwe  out  1  gated pc write enable
rwe  out  1  gated regfile write enable
mwe  out  1  gated data-memory write enable
commit  out  1  current instruction commits this cycle
running  out  1  state == RUN
bp_hit  out  1  sticky: last stop caused by breakpoint
wd_hit  out  1  sticky: last stop caused by watchdog
icount  out  CW  committed-instruction count

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous, active-high.
- States: HALT, RUN, STEP. Reset -> HALT; all outputs 0; icount=0; run-length counter=0; skip_bp=0.
- Gated enables are combinational: pwe=pwe_in&commit, rwe=rwe_in&commit, mwe=mwe_in&commit.
  - A pc that is not written (pwe_in=0) advances through its own increment, which is gated by commit at the pc.
- commit (combinational from state and inputs):
  - RUN: 1 unless halt=1, or breakpoint match, or watchdog expired.
  - STEP: 1.
  - HALT: 0.
- Breakpoint match = bp_en & (pa==bp_addr) & ~skip_bp. A matching instruction is NOT executed.
- Transitions, priority halt > step > run:
  - HALT:
    - halt -> HALT.
    - step -> STEP.
    - run -> RUN.
    - Either STEP or RUN clears bp_hit and wd_hit, sets skip_bp=1 and zeroes the run-length counter.
  - STEP: always -> HALT after its one commit. step held high yields one commit every 2 cycles.
  - RUN:
    - halt -> HALT, no commit.
    - breakpoint match -> HALT, bp_hit=1.
    - LIMIT!=0 and run-length==LIMIT -> HALT, wd_hit=1.
    - Otherwise stay in RUN and commit.
- skip_bp clears after the first commit following a resume, so resuming from a breakpoint executes the breakpointed instruction once. STEP always ignores the breakpoint.
- Counters:
  - icount increments on every commit and wraps at 2^CW.
  - The run-length counter increments per commit in RUN and saturates at LIMIT.
- Simultaneous breakpoint and watchdog: both sticky flags set.
- Reset mid-RUN: next cycle is HALT, commit=0 in the reset cycle, counters cleared.
- Outputs running, bp_hit, wd_hit and icount are registered.

Decomposition:
- Shared package: state encoding constants (HALT=2'd0, RUN=2'd1, STEP=2'd2) and the default widths AW/CW, so top and bench share them.
- No sub-module needed. The counter pair and the compare fit in one module.
- Top-level integration: insert between decoder and pc/regfile/omem; drive the pc increment enable from commit.

Test Plan:
- Reset then idle 10 cycles, with pwe_in=rwe_in=mwe_in=1 -> pwe=rwe=mwe=0, icount=0, running=0.
- run=1 for 5 cycles, then halt=1 -> 5 commits, icount=5, state HALT; halt wins when run and halt are both 1.
- bp_en=1, bp_addr=8'h04, run=1 from pa=0 with the pc incrementing -> commits at pa 0..3; at pa=4 commit=0, bp_hit=1, icount=4. Re-assert run -> pa 4 commits, bp_hit clears.
- From HALT, three step pulses 2 cycles apart -> exactly 3 commits, icount+3, state HALT after each; step at pa==bp_addr commits.
- LIMIT=3 build, run=1 held -> 3 commits, then HALT with wd_hit=1. Release run and re-assert -> 3 more commits.
- Assert rst during RUN with icount=7 -> the following cycle shows HALT, icount=0, all gated enables 0.
